// File: rtl/bus_arb_2m_if.sv
// Bus bundle for the two-master arbiter: both upstream master ports, the downstream port and the timeout flag.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface bus_arb_2m_if;
    logic        m0_valid;
    logic        m0_write;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic        m1_write;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic        s_write;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic        s_rvalid;
    logic [31:0] s_rdata;

    logic        timeout_flag;

    modport master (
        input  m0_valid, m0_write, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rvalid, m0_rdata,
        input  m1_valid, m1_write, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rvalid, m1_rdata,
        output s_valid, s_write, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rvalid, s_rdata,
        output timeout_flag
    );

    modport slave (
        output m0_valid, m0_write, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rvalid, m0_rdata,
        output m1_valid, m1_write, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rvalid, m1_rdata,
        input  s_valid, s_write, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rvalid, s_rdata,
        input  timeout_flag
    );
endinterface

// File: rtl/bus_arb_2m.sv
// Round-robin arbiter sharing one downstream port between two masters (IDLE -> ISSUE -> WAIT).
// Optional WAIT-state timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb_2m #(
`ifdef BUS_ARB_TIMEOUT_EN
    parameter int          TIMEOUT_CYC = 16,
`endif
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          rst,
    bus_arb_2m_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        r_gnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        w_req_any;
    logic        w_sel_m1;
    logic        w_in_wait;
    logic        w_wr_done;
    logic        w_rd_done;
    logic        w_timeout;
    logic        w_done;
    logic        w_resp_wr;
    logic        w_resp_rd;
    logic [31:0] w_rdata;

    // m1 wins only when alone or when it holds the round-robin priority
    assign w_req_any = bus.m0_valid | bus.m1_valid;
    assign w_sel_m1  = bus.m1_valid & (~bus.m0_valid | r_prio);

    // Slave responses count only in WAIT, only of the latched kind, and never in a reset cycle
    assign w_in_wait = (r_state == ST_WAIT) & ~rst;
    assign w_wr_done = w_in_wait & r_write & bus.s_ready;
    assign w_rd_done = w_in_wait & ~r_write & bus.s_rvalid;
    assign w_done    = w_wr_done | w_rd_done | w_timeout;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_flag;

    assign w_timeout = w_in_wait & ~w_wr_done & ~w_rd_done &
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // WAIT-cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt     <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if ((r_state == ST_WAIT) && !w_done) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_timeout_flag <= 1'b1;
            end else begin
                r_timeout_flag <= r_timeout_flag;
            end
        end
    end

    assign bus.timeout_flag = r_timeout_flag;
`else
    assign w_timeout        = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant capture and priority rotation; masters hold fields stable, so capturing once suffices
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_gnt   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wstrb <= 4'h0;
        end else begin
            if ((r_state == ST_IDLE) && w_req_any) begin
                r_gnt   <= w_sel_m1;
                r_write <= w_sel_m1 ? bus.m1_write : bus.m0_write;
                r_addr  <= w_sel_m1 ? bus.m1_addr  : bus.m0_addr;
                r_wdata <= w_sel_m1 ? bus.m1_wdata : bus.m0_wdata;
                r_wstrb <= w_sel_m1 ? bus.m1_wstrb : bus.m0_wstrb;
            end else begin
                r_gnt   <= r_gnt;
                r_write <= r_write;
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
                r_wstrb <= r_wstrb;
            end
            if (w_done) begin
                r_prio <= ~r_gnt;
            end else begin
                r_prio <= r_prio;
            end
        end
    end

    assign bus.s_valid = (r_state == ST_ISSUE);
    assign bus.s_write = r_write;
    assign bus.s_addr  = r_addr;
    assign bus.s_wdata = r_wdata;
    assign bus.s_wstrb = r_wstrb;

    // A genuine read response wins over a simultaneous timeout
    assign w_resp_wr = w_wr_done | (w_timeout & r_write);
    assign w_resp_rd = w_rd_done | (w_timeout & ~r_write);
    assign w_rdata   = w_rd_done ? bus.s_rdata : ERR_RDATA;

    assign bus.m0_ready  = w_resp_wr & ~r_gnt;
    assign bus.m1_ready  = w_resp_wr & r_gnt;
    assign bus.m0_rvalid = w_resp_rd & ~r_gnt;
    assign bus.m1_rvalid = w_resp_rd & r_gnt;
    assign bus.m0_rdata  = (w_resp_rd & ~r_gnt) ? w_rdata : 32'h0;
    assign bus.m1_rdata  = (w_resp_rd & r_gnt)  ? w_rdata : 32'h0;

endmodule

// File: tb/tb_bus_arb_2m.sv
// Self-checking bench for bus_arb_2m: directed scenarios plus randomized rounds against a transaction-level model.
// The timeout scenario runs only when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arb_2m;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arb_2m_if bus ();

    bus_arb_2m dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: pending request per master and the round-robin pointer
    logic        req_v [2];
    logic        req_w [2];
    logic [31:0] req_a [2];
    logic [31:0] req_d [2];
    logic [3:0]  req_s [2];
    int          mdl_prio;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk_val(tag, {26'd0, bus.m0_ready, bus.m0_rvalid, bus.m1_ready, bus.m1_rvalid,
                      |bus.m0_rdata, |bus.m1_rdata}, 32'd0);
    endtask

    task automatic drive_masters();
        bus.m0_valid = req_v[0]; bus.m0_write = req_w[0]; bus.m0_addr = req_a[0];
        bus.m0_wdata = req_d[0]; bus.m0_wstrb = req_s[0];
        bus.m1_valid = req_v[1]; bus.m1_write = req_w[1]; bus.m1_addr = req_a[1];
        bus.m1_wdata = req_d[1]; bus.m1_wstrb = req_s[1];
    endtask

    task automatic new_req(input int m, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_v[m] = 1'b1; req_w[m] = w; req_a[m] = a; req_d[m] = d; req_s[m] = s;
    endtask

    task automatic rand_req(input int m);
        logic [31:0] a;
        a    = $urandom;
        a[0] = (m == 1);
        new_req(m, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    endtask

    // One arbitration round starting at a negedge in IDLE; ends at the negedge of the next IDLE cycle
    task automatic run_round(input int dly, input bit noise, input logic [31:0] rd, output int win);
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        win = -1;
        drive_masters();
        bus.s_ready = noise; bus.s_rvalid = noise; bus.s_rdata = $urandom;
        #1;
        chk_val("idle_s_valid", 32'(bus.s_valid), 32'd0);
        chk_quiet("idle_quiet");
        if (!req_v[0] && !req_v[1]) begin
            @(negedge clk);
            return;
        end
        if (req_v[0] && req_v[1]) win = mdl_prio;
        else                      win = req_v[1] ? 1 : 0;

        @(negedge clk);
        bus.s_ready  = noise & 1'($urandom_range(0, 1));
        bus.s_rvalid = noise & 1'($urandom_range(0, 1));
        #1;
        chk_val("issue_s_valid", 32'(bus.s_valid), 32'd1);
        chk_val("issue_s_write", 32'(bus.s_write), 32'(req_w[win]));
        chk_val("issue_s_addr",  bus.s_addr,  req_a[win]);
        chk_val("issue_s_wdata", bus.s_wdata, req_d[win]);
        chk_val("issue_s_wstrb", 32'(bus.s_wstrb), 32'(req_s[win]));
        chk_quiet("issue_quiet");

        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            bus.s_ready  = noise & ~req_w[win];
            bus.s_rvalid = noise & req_w[win];
            bus.s_rdata  = $urandom;
            #1;
            chk_val("wait_s_valid", 32'(bus.s_valid), 32'd0);
            chk_val("wait_s_addr",  bus.s_addr, req_a[win]);
            chk_quiet("wait_quiet");
        end

        @(negedge clk);
        bus.s_ready  = req_w[win];
        bus.s_rvalid = ~req_w[win];
        bus.s_rdata  = rd;
        #1;
        e_rd0 = (win == 0 && !req_w[0]) ? rd : 32'h0;
        e_rd1 = (win == 1 && !req_w[1]) ? rd : 32'h0;
        chk_val("resp_m0_ready",  32'(bus.m0_ready),  32'(win == 0 && req_w[0]));
        chk_val("resp_m0_rvalid", 32'(bus.m0_rvalid), 32'(win == 0 && !req_w[0]));
        chk_val("resp_m0_rdata",  bus.m0_rdata, e_rd0);
        chk_val("resp_m1_ready",  32'(bus.m1_ready),  32'(win == 1 && req_w[1]));
        chk_val("resp_m1_rvalid", 32'(bus.m1_rvalid), 32'(win == 1 && !req_w[1]));
        chk_val("resp_m1_rdata",  bus.m1_rdata, e_rd1);
        chk_val("resp_timeout_flag", 32'(bus.timeout_flag), 32'd0);
        @(posedge clk);
        mdl_prio   = 1 - win;
        req_v[win] = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_val({tag, "_s_valid"}, 32'(bus.s_valid), 32'd0);
        chk_val({tag, "_s_write"}, 32'(bus.s_write), 32'd0);
        chk_val({tag, "_s_addr"},  bus.s_addr,  32'd0);
        chk_val({tag, "_s_wdata"}, bus.s_wdata, 32'd0);
        chk_val({tag, "_s_wstrb"}, 32'(bus.s_wstrb), 32'd0);
        chk_val({tag, "_timeout"}, 32'(bus.timeout_flag), 32'd0);
        chk_quiet({tag, "_quiet"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int win;
        for (int m = 0; m < 2; m++) begin
            req_v[m] = 1'b0; req_w[m] = 1'b0; req_a[m] = 32'h0; req_d[m] = 32'h0; req_s[m] = 4'h0;
        end
        mdl_prio = 0;
        rst = 1'b1;
        drive_masters();
        bus.s_ready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous reads after reset: m0 first, then m1
        new_req(0, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
        new_req(1, 1'b0, 32'h0000_3001, 32'h0, 4'h0);
        run_round(0, 1'b0, 32'h1111_2222, win);
        run_round(0, 1'b0, 32'hA5A5_0001, win);

        // Single m0 write, one-cycle slave
        new_req(0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF);
        run_round(0, 1'b0, 32'h0, win);

        // Write with a stray s_rvalid during WAIT (leaves priority with m1)
        new_req(0, 1'b1, 32'h0000_4000, 32'hCAFE_0001, 4'h3);
        run_round(2, 1'b1, 32'h0, win);

        // Reset in WAIT with s_rvalid present: aborted, priority back to m0
        new_req(1, 1'b0, 32'h0000_5001, 32'h0, 4'h0);
        drive_masters();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_quiet("abort_wait_quiet");
        @(negedge clk);
        rst = 1'b1; bus.s_rvalid = 1'b1; bus.s_rdata = 32'h7777_8888;
        #1;
        chk_quiet("abort_rst_quiet");
        @(negedge clk);
        rst = 1'b0; bus.s_rvalid = 1'b0;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        drive_masters();
        mdl_prio = 0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        new_req(0, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
        new_req(1, 1'b1, 32'h0000_6001, 32'h5555_AAAA, 4'hC);
        run_round(0, 1'b0, 32'h0BAD_F00D, win);

        // Both masters continuously valid: six alternating grants
        rand_req(0);
        if (!req_v[1]) rand_req(1);
        for (int i = 0; i < 6; i++) begin
            run_round(0, 1'b0, $urandom, win);
            if (win >= 0) rand_req(win);
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;

        // Randomized rounds
        for (int i = 0; i < 150; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!req_v[m] && ($urandom_range(0, 9) < 6)) rand_req(m);
            end
            run_round($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, win);
        end

`ifdef BUS_ARB_TIMEOUT_EN
        // Silent slave on an m1 read: error completion after 16 WAIT cycles, sticky flag
        req_v[0] = 1'b0;
        if (req_v[1]) run_round(0, 1'b0, 32'h0, win);
        new_req(1, 1'b0, 32'h0000_9001, 32'h0, 4'h0);
        drive_masters();
        bus.s_ready = 1'b0; bus.s_rvalid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            #1;
            chk_quiet("to_wait_quiet");
        end
        @(negedge clk);
        #1;
        chk_val("to_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
        chk_val("to_m1_rdata",  bus.m1_rdata, 32'hDEAD_BEEF);
        chk_val("to_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
        @(posedge clk);
        req_v[1] = 1'b0;
        drive_masters();
        repeat (3) @(negedge clk);
        #1;
        chk_val("to_flag_sticky", 32'(bus.timeout_flag), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_val("to_flag_cleared", 32'(bus.timeout_flag), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arb_2m.md
BUS_ARB_2M -- requirements
Module: bus_arb_2m

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, SHALL set WAIT-state cycles before timeout (only with BUS_ARB_TIMEOUT_EN).
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, SHALL set read data returned on timeout.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 m0_valid, m0_write  in  1 each  master 0 request, write select.
REQ-006 m0_addr, m0_wdata  in  32 each  master 0 address, write data.
REQ-007 m0_wstrb  in  4  master 0 byte strobes.
REQ-008 m0_ready, m0_rvalid  out  1 each  master 0 write-done, read-data-valid.
REQ-009 m0_rdata  out  32  master 0 read data.
REQ-010 m1_* SHALL mirror REQ-005..REQ-009 for master 1.
REQ-011 s_valid, s_write  out  1 each  downstream request, write select.
REQ-012 s_addr, s_wdata  out  32 each; s_wstrb  out  4  downstream request fields.
REQ-013 s_ready, s_rvalid  in  1 each; s_rdata  in  32  downstream response.
REQ-014 timeout_flag  out  1  sticky timeout indicator.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-016 Masters SHALL hold valid and all fields stable until their response; the arbiter SHALL rely on this.
REQ-017 IDLE: any mX_valid=1 SHALL latch the granted master's fields into registers and move to ISSUE next cycle.
REQ-018 Both valid in IDLE: grant SHALL go to the master holding round-robin priority; priority after reset = m0.
REQ-019 After a grant completes, priority SHALL pass to the non-granted master.
REQ-020 ISSUE: s_valid=1 for exactly one cycle, s_* driven from registers; next state WAIT.
REQ-021 WAIT, latched write: s_ready=1 SHALL assert granted mX_ready=1 in the same cycle (combinational); FSM -> IDLE.
REQ-022 WAIT, latched read: s_rvalid=1 SHALL assert granted mX_rvalid=1 and mX_rdata=s_rdata in the same cycle; FSM -> IDLE.
REQ-023 Non-granted master's ready/rvalid SHALL be 0 and its rdata 0 at all times.
REQ-024 s_ready/s_rvalid outside WAIT SHALL be ignored.
REQ-025 A response of the wrong kind in WAIT (s_ready on read, s_rvalid on write) SHALL be ignored.
REQ-026 Latency, single request with 1-cycle slave: valid at cycle 0 -> s_valid cycle 1 -> mX response cycle 2.
REQ-027 A master re-asserting valid in the cycle after its response SHALL be arbitrated normally from IDLE; back-to-back throughput is 1 transaction per 3 cycles.
REQ-028 s_valid SHALL be 0 in IDLE and WAIT; s_addr/s_wdata/s_wstrb/s_write SHALL hold the latched values until the next grant.

Reset
REQ-029 rst=1 SHALL force IDLE, priority=m0, s_valid=0, s_write=0, s_addr/s_wdata=0, s_wstrb=0, all mX_ready/mX_rvalid=0, mX_rdata=0, timeout_flag=0, timeout counter=0.
REQ-030 rst during ISSUE or WAIT SHALL abort the transaction; any s_ready/s_rvalid in the reset cycle SHALL NOT reach a master.

Configuration
REQ-031 Macro BUS_ARB_TIMEOUT_EN defined: WAIT counter SHALL count from 0 and, on reaching TIMEOUT_CYC-1 without a response, SHALL complete the grant (mX_ready=1 for a write; mX_rvalid=1 with mX_rdata=ERR_RDATA for a read), set timeout_flag (cleared only by rst) and return to IDLE.
REQ-032 Macro undefined: no counter SHALL be built, WAIT SHALL last indefinitely, and timeout_flag SHALL be tied to 0.

Verification
REQ-033 m0 write addr 0x1000, wdata 0x1234_5678, wstrb 0xF; slave ready 1 cycle after s_valid -> s_valid cycle 1 with those fields; m0_ready=1 cycle 2 only.
REQ-034 m0 and m1 reads asserted the same cycle after reset -> m0 granted first, m1 second; m1_rvalid carries slave rdata 0xA5A5_0001; m0 signals stay 0 during m1's grant.
REQ-035 Both masters continuously valid for 6 transactions -> grants alternate m0, m1, m0, m1, m0, m1.
REQ-036 rst pulsed in WAIT with slave s_rvalid in that cycle -> no mX_rvalid; all outputs at reset values next cycle.
REQ-037 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, read with silent slave -> after 16 WAIT cycles m1_rvalid=1, m1_rdata=0xDEAD_BEEF, timeout_flag=1 sticky until rst.
REQ-038 Slave raises s_rvalid during a write WAIT -> ignored; later s_ready completes the write normally.
